// File: rtl/top_k_tracker.sv
// Streaming top-K tracker: sorted register array of the K largest valid samples, with eviction reporting.
// Optional macro TOPK_UNIQUE_EN: drop plain-insert samples equal to any tracked value.
module top_k_tracker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K          = 4,
    parameter int unsigned RW         = $clog2(K)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      din_valid,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic [RW-1:0]             rank_sel,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    output logic [$clog2(K+1)-1:0]    count,
    output logic [K*DATA_WIDTH-1:0]   top_vals,
    output logic                      evict_valid,
    output logic [DATA_WIDTH-1:0]     evict_data
);

    localparam int unsigned CW = $clog2(K+1);

    logic [DATA_WIDTH-1:0] r_val      [K];
    logic [DATA_WIDTH-1:0] w_val_nxt  [K];
    logic [K-1:0]          r_occ;
    logic [K-1:0]          w_occ_nxt;
    logic [K-1:0]          w_qual;
    logic [K-1:0]          w_ge;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  r_evict_valid;
    logic                  w_evict_valid_nxt;
    logic [DATA_WIDTH-1:0] r_evict_data;
    logic [DATA_WIDTH-1:0] w_evict_data_nxt;
    logic                  w_ins;
`ifdef TOPK_UNIQUE_EN
    logic                  w_dup;
`endif

    // w_ge[i]: rank i is at or below the insert position (prefix-OR of qualifying ranks)
    always_comb begin
        w_qual = '0;
        w_ge   = '0;
        for (int i = 0; i < int'(K); i++) begin
            w_qual[i] = !r_occ[i] || (din > r_val[i]);
        end
        w_ge[0] = w_qual[0];
        for (int i = 1; i < int'(K); i++) begin
            w_ge[i] = w_ge[i-1] | w_qual[i];
        end
`ifdef TOPK_UNIQUE_EN
        w_dup = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            if (r_occ[i] && (din == r_val[i])) w_dup = 1'b1;
        end
        w_ins = din_valid && w_ge[K-1] && !w_dup;
`else
        w_ins = din_valid && w_ge[K-1];
`endif
    end

    // Next-state: clear (optionally with load) takes priority over a plain insert
    always_comb begin
        w_val_nxt         = r_val;
        w_occ_nxt         = r_occ;
        w_count_nxt       = r_count;
        w_evict_valid_nxt = 1'b0;
        w_evict_data_nxt  = r_evict_data;
        if (clear) begin
            for (int i = 0; i < int'(K); i++) w_val_nxt[i] = '0;
            w_occ_nxt   = '0;
            w_count_nxt = '0;
            if (din_valid) begin
                w_val_nxt[0] = din;
                w_occ_nxt[0] = 1'b1;
                w_count_nxt  = CW'(1);
            end
        end else if (w_ins) begin
            if (w_qual[0]) begin
                w_val_nxt[0] = din;
                w_occ_nxt[0] = 1'b1;
            end
            for (int i = 1; i < int'(K); i++) begin
                if (w_ge[i-1]) begin
                    w_val_nxt[i] = r_val[i-1];
                    w_occ_nxt[i] = r_occ[i-1];
                end else if (w_qual[i]) begin
                    w_val_nxt[i] = din;
                    w_occ_nxt[i] = 1'b1;
                end
            end
            if (r_occ[K-1]) begin
                w_evict_valid_nxt = 1'b1;
                w_evict_data_nxt  = r_val[K-1];
            end else begin
                w_count_nxt = r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(K); i++) r_val[i] <= '0;
            r_occ         <= '0;
            r_count       <= '0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
        end else begin
            r_val         <= w_val_nxt;
            r_occ         <= w_occ_nxt;
            r_count       <= w_count_nxt;
            r_evict_valid <= w_evict_valid_nxt;
            r_evict_data  <= w_evict_data_nxt;
        end
    end

    // Read path masks empty ranks so stale storage never leaks out
    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        top_vals   = '0;
        for (int i = 0; i < int'(K); i++) begin
            if (r_occ[i]) top_vals[i*DATA_WIDTH +: DATA_WIDTH] = r_val[i];
            if (rank_sel == RW'(i)) begin
                dout_valid = r_occ[i];
                dout       = r_occ[i] ? r_val[i] : '0;
            end
        end
    end

    assign count       = r_count;
    assign evict_valid = r_evict_valid;
    assign evict_data  = r_evict_data;

endmodule

// File: tb/tb_top_k_tracker.sv
// Bench for top_k_tracker: directed scenarios then random traffic against a sorted-queue reference.
module tb_top_k_tracker;

    localparam int unsigned DW  = 32;
    localparam int unsigned K   = 4;
    localparam int unsigned RW  = 2;
    localparam int unsigned CW  = 3;
    localparam int unsigned TVW = K*DW;

    logic           clk = 1'b0;
    logic           resetn;
    logic           clear;
    logic           din_valid;
    logic [DW-1:0]  din;
    logic [RW-1:0]  rank_sel;
    logic [DW-1:0]  dout;
    logic           dout_valid;
    logic [CW-1:0]  count;
    logic [TVW-1:0] top_vals;
    logic           evict_valid;
    logic [DW-1:0]  evict_data;

    top_k_tracker #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid),
        .din(din), .rank_sel(rank_sel), .dout(dout), .dout_valid(dout_valid),
        .count(count), .top_vals(top_vals), .evict_valid(evict_valid),
        .evict_data(evict_data)
    );

    always #10 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: descending queue of tracked values plus last eviction
    int unsigned mq[$];
    bit          m_ev;
    logic [DW-1:0] m_evd;

    task automatic chk(input string tag, input logic [TVW-1:0] obs, input logic [TVW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_step(input bit v, input bit c, input int unsigned d);
        int  pos;
        bit  found;
        bit  drop;
        m_ev  = 1'b0;
        drop  = 1'b0;
        found = 1'b0;
        if (c) begin
            mq.delete();
            if (v) mq.push_back(d);
        end else if (v) begin
`ifdef TOPK_UNIQUE_EN
            foreach (mq[i]) if (mq[i] == d) drop = 1'b1;
`endif
            if (!drop) begin
                pos = mq.size();
                foreach (mq[i]) begin
                    if (!found && d > mq[i]) begin
                        pos   = i;
                        found = 1'b1;
                    end
                end
                if (pos < int'(K)) begin
                    mq.insert(pos, d);
                    if (mq.size() > int'(K)) begin
                        m_evd = mq.pop_back();
                        m_ev  = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [TVW-1:0] model_tv();
        logic [TVW-1:0] tv = '0;
        foreach (mq[i]) tv[i*DW +: DW] = mq[i];
        return tv;
    endfunction

    task automatic check_all();
        chk("count", TVW'(count), TVW'(mq.size()));
        chk("top_vals", top_vals, model_tv());
        chk("evict_valid", TVW'(evict_valid), TVW'(m_ev));
        chk("evict_data", TVW'(evict_data), TVW'(m_evd));
        for (int r = 0; r < int'(K); r++) begin
            rank_sel = RW'(r);
            #1;
            chk("dout", TVW'(dout), (r < mq.size()) ? TVW'(mq[r]) : '0);
            chk("dout_valid", TVW'(dout_valid), TVW'(r < mq.size()));
        end
    endtask

    task automatic step(input bit v, input bit c, input logic [DW-1:0] d);
        @(negedge clk);
        din_valid = v;
        clear     = c;
        din       = d;
        @(posedge clk);
        model_step(v, c, d);
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
        check_all();
    endtask

    // Reset asserted mid-cycle must clear outputs with no clock edge
    task automatic reset_mid();
        #2;
        resetn = 1'b0;
        #1;
        mq.delete();
        m_ev  = 1'b0;
        m_evd = '0;
        chk("rst_count", TVW'(count), '0);
        chk("rst_top_vals", top_vals, '0);
        chk("rst_dout_valid", TVW'(dout_valid), '0);
        chk("rst_dout", TVW'(dout), '0);
        chk("rst_evict", TVW'({evict_valid, evict_data}), '0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        clear     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        rank_sel  = '0;
        m_ev      = 1'b0;
        m_evd     = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check_all();

        // Fill and order
        step(1, 0, 5); step(1, 0, 9); step(1, 0, 1); step(1, 0, 7);
        chk("fill_tv", top_vals, {32'd1, 32'd5, 32'd7, 32'd9});
        chk("fill_count", TVW'(count), TVW'(4));
        rank_sel = 2'd1;
        #1;
        chk("fill_dout_sel1", TVW'(dout), TVW'(7));

        // Eviction, one-cycle pulse, then a dropped sample
        step(1, 0, 8);
        chk("evict_tv", top_vals, {32'd5, 32'd7, 32'd8, 32'd9});
        chk("evict_pulse", TVW'({evict_valid, evict_data}), {1'b1, 32'd1});
        step(0, 0, 0);
        chk("evict_pulse_end", TVW'(evict_valid), '0);
        step(1, 0, 3);
        chk("drop_tv", top_vals, {32'd5, 32'd7, 32'd8, 32'd9});
        chk("drop_no_evict", TVW'(evict_valid), '0);

        // Clear-and-load, then clear alone
        step(1, 1, 2);
        chk("clrload_tv", top_vals, TVW'(2));
        chk("clrload_count", TVW'(count), TVW'(1));
        chk("clrload_no_evict", TVW'(evict_valid), '0);
        step(0, 1, 0);
        chk("clear_count", TVW'(count), '0);

        // Duplicates
        step(1, 0, 6); step(1, 0, 6); step(1, 0, 4);
`ifdef TOPK_UNIQUE_EN
        chk("dup_tv", top_vals, {32'd0, 32'd0, 32'd4, 32'd6});
        chk("dup_count", TVW'(count), TVW'(2));
`else
        chk("dup_tv", top_vals, {32'd0, 32'd4, 32'd6, 32'd6});
        chk("dup_count", TVW'(count), TVW'(3));
`endif

        // Partial read of an empty rank
        step(0, 1, 0);
        step(1, 0, 10); step(1, 0, 20);
        rank_sel = 2'd3;
        #1;
        chk("partial_dout", TVW'(dout), '0);
        chk("partial_dout_valid", TVW'(dout_valid), '0);

        reset_mid();
        step(1, 0, 3);
        chk("post_reset_rank0", top_vals, TVW'(3));

        // Random traffic with occasional clears and mid-stream resets
        for (int n = 0; n < 400; n++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(3) == 0) ? DW'($urandom) : DW'($urandom_range(15));
            step($urandom_range(3) != 0, $urandom_range(24) == 0, d);
            if (n % 97 == 96) reset_mid();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/top_k_tracker.md
# top_k_tracker

Streaming top-K tracker: keeps the K largest values seen on a valid-qualified input stream as a sorted register array. Rank 0 is the largest; ranks fill in descending order. Any rank can be read through a select port, and all ranks are exposed on a flattened bus. It generalises the fixed two-entry largest/second-largest tracker with:
- a configurable depth K;
- input qualification;
- explicit empty tracking;
- synchronous clear;
- eviction reporting.

## Interface
- `DATA_WIDTH`, 32, width of each unsigned sample.
- `K`, 4, number of tracked ranks; legal range 2..64.
- `RW`, `$clog2(K)`, width of `rank_sel` (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  reset, asynchronous and active-low; the only clock is `clk`.
- `clear`  in  1  synchronous flush of all ranks.
- `din_valid`  in  1  `din` is sampled this cycle.
- `din`  in  `DATA_WIDTH`  unsigned sample.
- `rank_sel`  in  `RW`  rank to present on `dout`.
- `dout`  out  `DATA_WIDTH`  value at `rank_sel`; 0 if that rank is empty or `rank_sel` ≥ K.
- `dout_valid`  out  1  selected rank holds a value.
- `count`  out  `$clog2(K+1)`  number of filled ranks (0..K).
- `top_vals`  out  `K*DATA_WIDTH`  all ranks; rank i at bits [i*DATA_WIDTH +: DATA_WIDTH]; empty ranks read 0.
- `evict_valid`  out  1  one-cycle pulse: a value was pushed out of rank K-1.
- `evict_data`  out  `DATA_WIDTH`  the pushed-out value; holds its last value when not pulsing.

## Operation
- **State.** Per rank i there is a value `val[i]` and a flag `occ[i]`.
  - `occ` is always a prefix: ranks 0..count-1 are filled.
  - Filled values are non-increasing from rank 0 down.
- **Insert position.** On a cycle with `din_valid`=1 and `clear`=0:
  - Rank i qualifies when `!occ[i] || din > val[i]` (unsigned, strict).
  - p = the lowest qualifying rank.
- **Insert update.**
  - Ranks below p hold.
  - Rank p loads `din`.
  - Ranks i>p load `val[i-1]`/`occ[i-1]`.
  - `count` increments, saturating at K.
- **Eviction.** If `count`=K and p exists, the old `val[K-1]` appears on `evict_data` and `evict_valid` pulses.
- **No qualifying rank** (`count`=K and `din` ≤ every value): the sample is dropped, with no state change and no evict.
- **Equal values.** A sample equal to an existing value does not qualify at that rank, so it lands below all equal entries (stable ordering).
  - Duplicates occupy separate ranks unless `TOPK_UNIQUE_EN` is defined.
- **`clear`=1 with `din_valid`=0:** all `occ` and `val` go to 0, `count` goes to 0, no evict.
- **`clear`=1 with `din_valid`=1:** clear-and-load.
  - Rank 0 takes `din`, all other ranks are emptied, `count` becomes 1.
  - Nothing is evicted.
- **`din_valid`=0 and `clear`=0:** state holds.
- **Read path.** `dout`, `dout_valid` and `top_vals` are combinational from the registered array plus `rank_sel`.
  - Empty ranks must read 0 regardless of stale storage.

## Timing
- **Latency.** A sample taken on edge n is visible on `top_vals`/`dout`/`count` after edge n; it is readable in cycle n+1.
- **Eviction.** `evict_valid`/`evict_data` are registered and update on the same edge as the array.
- **Read response.** A `rank_sel` change shows on `dout` in the same cycle, with no clock involved.
- **Throughput.** One sample per cycle, every cycle; there is no backpressure.
- **Reset values.** Asserting `resetn` low immediately forces:
  - all `val`=0 and `occ`=0;
  - `count`=0, `evict_valid`=0, `evict_data`=0;
  - hence `dout`=0, `dout_valid`=0, `top_vals`=0.
- **Reset mid-stream.** Reset aborts any in-flight update; the first sample after deassertion is written to rank 0.
- **Priority.** `resetn` over `clear`, and `clear` over a plain insert.

## Configuration
- `TOPK_UNIQUE_EN` undefined (default): duplicate values are tracked in separate ranks as described above.
- `TOPK_UNIQUE_EN` defined: a sample equal to any filled `val[i]` is dropped.
  - No state change, no evict, `count` unchanged.
  - Applies to the plain-insert path only; clear-and-load always loads.
  - All ranks are then strictly decreasing.

## Test plan
- **Reset:** K=4, drive `resetn` low mid-cycle → `count`=0, `dout_valid`=0, `top_vals`=0 without waiting for a clock edge.
- **Fill and order:** feed 5, 9, 1, 7 → `top_vals` ranks 0..3 = 9, 7, 5, 1, `count`=4, no evict; `rank_sel`=1 gives `dout`=7 in the same cycle.
- **Eviction:**
  - With 9, 7, 5, 1 loaded, feed 8 → ranks 9, 8, 7, 5, `evict_valid`=1, `evict_data`=1 for exactly one cycle.
  - Then feed 3 → dropped, no pulse, state unchanged.
- **Duplicates:** from empty, feed 6, 6, 4 with the macro undefined → ranks 6, 6, 4, empty, `count`=3.
  - With `TOPK_UNIQUE_EN` defined → ranks 6, 4, empty, empty, `count`=2.
- **Clear:**
  - With the array full, `clear`+`din_valid`+`din`=2 → rank 0=2, ranks 1..3 empty/0, `count`=1, no evict.
  - `clear` alone → `count`=0.
- **Partial read:** with `count`=2, `rank_sel`=3 → `dout`=0, `dout_valid`=0.
